// File: rtl/probe_uplink_arbiter.sv
// probe_uplink_arbiter: round-robin drain of per-probe uplink messages onto a
// single registered 32-bit valid/ready stream. One message (header + W data
// words) is moved at a time, with one ACK pulse to the owning probe per word.
// Optional build macro PROBE_ARB_SEQNUM_EN stamps an 8-bit message sequence
// number into header bits [15:8].
module probe_uplink_arbiter #(
  parameter int NumProbes = 4
) (
  input  logic                    UCLK,
  input  logic                    URST,
  input  logic [32*NumProbes-1:0] DATAUP_IN,
  input  logic [NumProbes-1:0]    DATAVALID_IN,
  input  logic [NumProbes-1:0]    DELAY_IN,
  output logic [NumProbes-1:0]    ACK_OUT,
  output logic                    DELAY_OUT,
  output logic [31:0]             OUT_DATA,
  output logic                    OUT_VALID,
  output logic                    OUT_LAST,
  input  logic                    OUT_READY,
  output logic                    ERR
);

  localparam int IW = (NumProbes > 1) ? $clog2(NumProbes) : 1;

  typedef enum logic [1:0] {IDLE, XFER, GAP, DONE} state_t;

  state_t        state;
  logic [IW-1:0] gnt;       // probe currently being drained
  logic [IW-1:0] rr;        // round-robin search start
  logic [IW-1:0] pick;      // next probe to grant from rr
  logic [IW-1:0] gnt_nxt;   // gnt + 1 modulo NumProbes
  logic [7:0]    cnt;       // data words still to capture
  logic          hdr;       // next capture is the header word
  logic          any_req;
  logic          slot_free;
  logic [31:0]   word;
  logic [31:0]   cap_word;
  logic          cap_last;
`ifdef PROBE_ARB_SEQNUM_EN
  logic [7:0]    seq;
`endif

  assign DELAY_OUT = |DELAY_IN;
  assign slot_free = !OUT_VALID || OUT_READY;
  assign word      = DATAUP_IN[32*int'(gnt) +: 32];
  assign gnt_nxt   = (int'(gnt) == NumProbes - 1) ? '0 : gnt + 1'b1;

  // First requesting probe at or after rr, wrapping around.
  always_comb begin
    int idx;
    pick    = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < NumProbes; k++) begin
      idx = int'(rr) + k;
      if (idx >= NumProbes) idx = idx - NumProbes;
      if (!any_req && DATAVALID_IN[idx[IW-1:0]]) begin
        pick    = idx[IW-1:0];
        any_req = 1'b1;
      end
    end
  end

  // Word to capture and whether it ends the message.
  always_comb begin
    cap_word = word;
    cap_last = hdr ? (word[7:0] == 8'd0) : (cnt == 8'd1);
`ifdef PROBE_ARB_SEQNUM_EN
    if (hdr) cap_word[15:8] = seq;
`endif
  end

  // Arbitration FSM with registered stream outputs and ACK pulses.
  always_ff @(posedge UCLK or negedge URST) begin
    if (!URST) begin
      state     <= IDLE;
      gnt       <= '0;
      rr        <= '0;
      cnt       <= '0;
      hdr       <= 1'b0;
      ACK_OUT   <= '0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
      OUT_LAST  <= 1'b0;
      ERR       <= 1'b0;
`ifdef PROBE_ARB_SEQNUM_EN
      seq       <= '0;
`endif
    end else begin
      ACK_OUT <= '0;
      // Consumed word drops out unless replaced by a capture below.
      if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
        OUT_LAST  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt   <= pick;
            hdr   <= 1'b1;
            state <= XFER;
          end
        end
        XFER: begin
          if (!DATAVALID_IN[gnt]) begin
            // Probe vanished before its last word: flag, skip it, rearbitrate.
            ERR   <= 1'b1;
            rr    <= gnt_nxt;
            state <= IDLE;
`ifdef PROBE_ARB_SEQNUM_EN
            seq   <= seq + 8'd1;
`endif
          end else if (slot_free) begin
            OUT_DATA     <= cap_word;
            OUT_VALID    <= 1'b1;
            OUT_LAST     <= cap_last;
            ACK_OUT[gnt] <= 1'b1;
            hdr          <= 1'b0;
            if (hdr) cnt <= word[7:0];
            else     cnt <= cnt - 8'd1;
            if (cap_last) begin
              state <= DONE;
`ifdef PROBE_ARB_SEQNUM_EN
              seq   <= seq + 8'd1;
`endif
            end else begin
              state <= GAP;
            end
          end
        end
        // Let the probe present its next word after the ACK.
        GAP: state <= XFER;
        // Let the probe drop DATAVALID so it is not re-granted on stale state.
        DONE: begin
          rr    <= gnt_nxt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_probe_uplink_arbiter.sv
// Bench for probe_uplink_arbiter: behavioural probe models feed messages,
// a stream monitor collects output words, expected streams are built from
// message tables and compared word by word.
module tb_probe_uplink_arbiter;

  localparam int NP = 4;

  logic            UCLK;
  logic            URST;
  logic [32*NP-1:0] DATAUP_IN;
  logic [NP-1:0]   DATAVALID_IN;
  logic [NP-1:0]   DELAY_IN;
  logic [NP-1:0]   ACK_OUT;
  logic            DELAY_OUT;
  logic [31:0]     OUT_DATA;
  logic            OUT_VALID;
  logic            OUT_LAST;
  logic            OUT_READY;
  logic            ERR;

  probe_uplink_arbiter #(.NumProbes(NP)) dut (
    .UCLK(UCLK), .URST(URST), .DATAUP_IN(DATAUP_IN), .DATAVALID_IN(DATAVALID_IN),
    .DELAY_IN(DELAY_IN), .ACK_OUT(ACK_OUT), .DELAY_OUT(DELAY_OUT),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_LAST(OUT_LAST),
    .OUT_READY(OUT_READY), .ERR(ERR)
  );

  typedef struct { logic [31:0] exp; logic last; } vec_t;
  typedef struct { int src; int w; logic [31:0] base; } msg_t;
  typedef struct { logic [NP-1:0] din; logic dout; } dly_t;

  int n_chk = 0;
  int n_pass = 0;
  int inv_err = 0;
  int cyc = 0;

  logic [31:0] wq [NP][$];   // words each probe still has to send
  int          abort_at [NP];
  bit          act [NP];
  int          pos [NP];
  int          rem [NP];
  logic [NP-1:0] ack_seen;
  logic [NP-1:0] ack_prev;
  vec_t        vt [$];       // expected output stream
  logic [32:0] got [$];      // observed {last, data}
  int          ack_t [$];    // cycles where probe 2 was acked
  logic [7:0]  exp_seq;

  initial UCLK = 1'b0;
  always #5 UCLK = ~UCLK;
  always @(posedge UCLK) cyc <= cyc + 1;
  always @(posedge UCLK or negedge URST)
    if (!URST) ack_seen <= '0;
    else       ack_seen <= ACK_OUT;

  task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_chk++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act_v, exp_v);
  endtask

  // Probe model: registered-style update on the cycle after each ACK.
  initial begin
    DATAVALID_IN = '0;
    DATAUP_IN = '0;
    forever begin
      @(negedge UCLK);
      for (int i = 0; i < NP; i++) begin
        if (!URST) begin
          act[i] = 1'b0;
          DATAVALID_IN[i] = 1'b0;
        end else if (act[i]) begin
          if (ack_seen[i]) begin
            if (wq[i].size() > 0) void'(wq[i].pop_front());
            pos[i]++;
            rem[i]--;
            if (rem[i] == 0 || pos[i] == abort_at[i]) begin
              act[i] = 1'b0;
              DATAVALID_IN[i] = 1'b0;
              abort_at[i] = 0;
            end
          end
        end else if (wq[i].size() > 0) begin
          act[i] = 1'b1;
          pos[i] = 0;
          rem[i] = int'(wq[i][0][7:0]) + 1;
          DATAVALID_IN[i] = 1'b1;
        end
        if (wq[i].size() > 0) DATAUP_IN[32*i +: 32] = wq[i][0];
      end
    end
  end

  // Stream monitor and per-cycle ACK invariants.
  initial begin
    ack_prev = '0;
    forever begin
      @(negedge UCLK);
      if (URST) begin
        if (OUT_VALID && OUT_READY) got.push_back({OUT_LAST, OUT_DATA});
        if ($countones(ACK_OUT) > 1) inv_err++;
        if (ACK_OUT != '0 && !OUT_VALID) inv_err++;
        if ((ACK_OUT & ack_prev) != '0) inv_err++;
        if (ACK_OUT[2]) ack_t.push_back(cyc);
        ack_prev = ACK_OUT;
      end else begin
        ack_prev = '0;
      end
    end
  end

  task automatic add_msg(input int src, input int w, input logic [7:0] mid,
                         input logic [31:0] base, input int ab);
    logic [31:0] h, he;
    vec_t v;
    h  = {16'(src), mid, 8'(w)};
    he = h;
`ifdef PROBE_ARB_SEQNUM_EN
    he[15:8] = exp_seq;
`endif
    if (ab > 0) abort_at[src] = ab;
    wq[src].push_back(h);
    v.exp = he; v.last = (w == 0); vt.push_back(v);
    for (int j = 1; j <= w; j++) begin
      if (ab > 0 && j >= ab) break;
      wq[src].push_back(base + 32'(j));
      v.exp = base + 32'(j); v.last = (j == w); vt.push_back(v);
    end
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NP; i++) begin
      wq[i].delete();
      abort_at[i] = 0;
    end
    vt.delete(); got.delete(); ack_t.delete();
    exp_seq = 8'd0;
  endtask

  task automatic do_reset();
    URST = 1'b0;
    clear_all();
    repeat (2) @(negedge UCLK);
    #2 URST = 1'b1;
  endtask

  task automatic check_stream(input string nm, input int budget);
    int c;
    c = 0;
    while (got.size() < vt.size() && c < budget) begin
      @(negedge UCLK);
      c++;
    end
    repeat (6) @(negedge UCLK);
    chk({nm, " count"}, 64'(got.size()), 64'(vt.size()));
    for (int k = 0; k < vt.size(); k++)
      chk($sformatf("%s word%0d", nm, k), (k < got.size()) ? 64'(got[k]) : 64'hDEAD,
          {31'd0, vt[k].last, vt[k].exp});
  endtask

  msg_t rr_tbl [4];
  dly_t dtab [4];

  initial begin
    int c;
    bit found;
    rr_tbl[0] = '{0, 1, 32'h0000_A000};
    rr_tbl[1] = '{1, 1, 32'h0001_B000};
    rr_tbl[2] = '{3, 1, 32'h0003_C000};
    rr_tbl[3] = '{0, 1, 32'h0000_A100};
    dtab[0] = '{4'b0000, 1'b0};
    dtab[1] = '{4'b0001, 1'b1};
    dtab[2] = '{4'b1000, 1'b1};
    dtab[3] = '{4'b0110, 1'b1};

    URST = 1'b0; OUT_READY = 1'b1; DELAY_IN = '0;
    clear_all();
    for (int i = 0; i < NP; i++) begin act[i] = 1'b0; pos[i] = 0; rem[i] = 0; end
    #12;
    chk("rst OUT_VALID", OUT_VALID, 0);
    chk("rst OUT_LAST", OUT_LAST, 0);
    chk("rst OUT_DATA", OUT_DATA, 0);
    chk("rst ACK_OUT", ACK_OUT, 0);
    chk("rst ERR", ERR, 0);
    for (int k = 0; k < 4; k++) begin
      DELAY_IN = dtab[k].din;
      #1 chk($sformatf("delay%0d", k), DELAY_OUT, dtab[k].dout);
    end
    DELAY_IN = '0;
    URST = 1'b1;

    // Single probe, three words
    do_reset();
    add_msg(2, 2, 8'h00, 32'hAAAA_0000, 0);
    check_stream("single", 60);
    chk("single ack count", 64'(ack_t.size()), 3);
    chk("single ack gap1", (ack_t.size() >= 2) ? 64'(ack_t[1] - ack_t[0]) : 64'hFF, 2);
    chk("single ack gap2", (ack_t.size() >= 3) ? 64'(ack_t[2] - ack_t[1]) : 64'hFF, 2);

    // Round-robin: 0,1,3 at once, 0 re-requests
    do_reset();
    for (int k = 0; k < 4; k++) add_msg(rr_tbl[k].src, rr_tbl[k].w, 8'h00, rr_tbl[k].base, 0);
    check_stream("rr", 120);

    // Backpressure mid-message
    do_reset();
    add_msg(1, 3, 8'h00, 32'h1111_0000, 0);
    c = 0; found = 0;
    while (!found && c < 60) begin
      @(posedge UCLK); #1; c++;
      if (OUT_VALID && OUT_DATA == 32'h1111_0001) found = 1;
    end
    chk("bp reached", 64'(found), 1);
    OUT_READY = 1'b0;
    @(negedge UCLK);
    repeat (5) begin
      @(negedge UCLK);
      chk("bp hold valid", OUT_VALID, 1);
      chk("bp hold data", OUT_DATA, 32'h1111_0001);
      chk("bp no ack", ACK_OUT, 0);
    end
    @(posedge UCLK); #1 OUT_READY = 1'b1;
    check_stream("bp", 60);

    // Abort after the header, then next requester
    do_reset();
    add_msg(2, 3, 8'h00, 32'h2222_0000, 1);
    c = 0;
    while (!ERR && c < 40) begin @(negedge UCLK); c++; end
    chk("abort err set", ERR, 1);
    add_msg(0, 1, 8'h00, 32'h0000_D000, 0);
    check_stream("abort", 60);
    chk("abort err sticky", ERR, 1);

    // Async reset during a message
    add_msg(3, 3, 8'h00, 32'h3333_0000, 0);
    c = 0;
    while (ACK_OUT == '0 && c < 40) begin @(negedge UCLK); c++; end
    chk("mid ack seen", 64'(ACK_OUT != '0), 1);
    #2 URST = 1'b0;
    #1;
    chk("arst OUT_VALID", OUT_VALID, 0);
    chk("arst ACK_OUT", ACK_OUT, 0);
    chk("arst ERR", ERR, 0);
    chk("arst OUT_LAST", OUT_LAST, 0);
    clear_all();
    @(negedge UCLK);
    add_msg(1, 1, 8'h00, 32'h0101_0000, 0);
    add_msg(3, 1, 8'h00, 32'h0303_0000, 0);
    #2 URST = 1'b1;
    check_stream("arst order", 60);

    // 257 back-to-back W=0 messages (sequence stamp wraps when enabled)
    do_reset();
    for (int k = 0; k < 257; k++) add_msg(0, 0, 8'h5A, 32'h0, 0);
    check_stream("seq", 3000);

    chk("ack invariants", 64'(inv_err), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/probe_uplink_arbiter.md
Name: probe_uplink_arbiter

Overview:
- Sits downstream of the per-probe value-capture stages on the uplink side; one instance serves NumProbes probes.
- Round-robin arbitrates among probes with DATAVALID asserted.
- Drains one complete message (header plus data words) at a time, pulsing that probe's ACK once per word.
- Presents the words on a single registered 32-bit valid/ready stream toward the serial uplink transport.

Parameters:
- NumProbes, 4, number of probe uplink ports (1..16).

Ports:
- UCLK  input  1  uplink clock; all logic on posedge.
- URST  input  1  reset, asynchronous, active-low.
- DATAUP_IN  input  32*NumProbes  probe i word at bits [32*i+31:32*i].
- DATAVALID_IN  input  NumProbes  probe i has a message in progress.
- DELAY_IN  input  NumProbes  probe i has pending unsent data.
- ACK_OUT  output  NumProbes  one-cycle word-accept pulse to probe i.
- DELAY_OUT  output  1  OR of DELAY_IN, combinational.
- OUT_DATA  output  32  uplink word.
- OUT_VALID  output  1  OUT_DATA valid.
- OUT_LAST  output  1  OUT_DATA is the final word of a message.
- OUT_READY  input  1  consumer accepts the word when OUT_VALID && OUT_READY.
- ERR  output  1  sticky: the granted probe dropped DATAVALID mid-message.

Behaviour:
- Message format from a probe:
  - Header word: [31:16] probe id, [15:8] zero, [7:0] W.
  - Followed by W data words; W+1 words total.
  - The probe updates DATAUP on the cycle after each ACK and drops DATAVALID on the cycle after the final ACK.
- Reset (URST low, async): ACK_OUT=0, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0, ERR=0, state IDLE, rr pointer 0, word counter 0.
- Output register:
  - "slot free" = !OUT_VALID || OUT_READY.
  - On a handshake with no new capture, OUT_VALID clears next cycle.
- IDLE:
  - If any DATAVALID_IN is set, grant the first set index at or after the rr pointer, wrapping modulo NumProbes.
  - Move to XFER. Grant is registered, so the first capture happens at the earliest on the cycle after grant.
- XFER:
  - Condition: DATAVALID_IN[g] && slot free.
  - On that condition: OUT_DATA <= DATAUP_IN[g], OUT_VALID <= 1, ACK_OUT[g] pulses high for exactly this cycle, go to GAP.
  - For the header word, load counter <= W (header bits [7:0]). For data words, counter decrements.
  - OUT_LAST <= 1 when capturing the header with W==0, or a data word with counter==1.
  - After capturing the last word, go to DONE instead of GAP.
- GAP:
  - One dead cycle so the probe's updated DATAUP is visible; no ACK; return to XFER.
  - Steady-state throughput is therefore one word per 2 cycles.
- DONE:
  - rr pointer <= g+1 (mod NumProbes).
  - Wait one cycle for the probe to drop DATAVALID, then go to IDLE. This prevents a stale re-grant.
- Abort: if DATAVALID_IN[g] is low in XFER before the last word:
  - Set ERR.
  - Force OUT_LAST on the next captured word: none, so emit nothing extra.
  - Advance rr, go to IDLE.
- Invariants:
  - Never more than one ACK_OUT bit high.
  - Never an ACK without a simultaneous capture.
  - Never two ACKs to a probe on consecutive cycles.
- Backpressure: OUT_READY low holds OUT_DATA/OUT_VALID/OUT_LAST stable and stalls XFER with no ACK.
- Simultaneous requests: order is strictly round-robin from the rr pointer. DELAY_IN does not affect arbitration.
- Reset mid-message: everything returns to reset values immediately. Upstream probes share URST and restart too.

Optional Feature:
PROBE_ARB_SEQNUM_EN
- Defined:
  - An 8-bit message sequence counter, reset 0, overwrites header bits [15:8] on the header word only.
  - It increments when a message's last word is captured and wraps 255->0.
  - Aborted messages also increment it, so the host detects gaps.
- Not defined: headers pass through unmodified, with bits [15:8] as received.

Test Plan:
- Single-probe transfer:
  - Stimulus: NumProbes=4; probe 2 presents header 0x0002_0002 then data 0xAAAA0001, 0xAAAA0002; OUT_READY=1.
  - Response: 3 words out in order; ACK_OUT[2] pulses 3 times, each 2 cycles apart; OUT_LAST only on 0xAAAA0002.
- Round-robin fairness:
  - Stimulus: probes 0, 1, 3 request together with W=1 each; after 0's message completes, 0 requests again.
  - Response: service order is 0, 1, 3, 0.
- Backpressure:
  - Stimulus: OUT_READY low for 5 cycles mid-message.
  - Response: OUT_DATA stable and valid throughout; no ACK pulses; transfer resumes with no words lost or duplicated.
- Abort:
  - Stimulus: granted probe drops DATAVALID after the header with W=3.
  - Response: ERR=1 and stays set; arbiter returns to IDLE and serves the next requester normally.
- Async reset mid-transfer:
  - Stimulus: assert URST low between clock edges during a message.
  - Response: OUT_VALID, ACK_OUT and ERR go to 0 without waiting for a UCLK edge; after release, the first grant goes to the lowest requesting index.
- With PROBE_ARB_SEQNUM_EN:
  - Stimulus: 257 back-to-back W=0 messages.
  - Response: header bits [15:8] read 0, 1, ..., 255, 0.
